// File: rtl/kbd_ascii_fifo_if.sv
// Keyboard-side scan input, CPU-side read strobe and the buffered ASCII/status outputs.
interface kbd_ascii_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic [15:0]   char;
  logic          key;
  logic          rd_en;
  logic [7:0]    ascii;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          caps_lock;
  logic [CW-1:0] fill_count;

  modport master (
    output char, key, rd_en,
    input  ascii, empty, full, overflow, caps_lock, fill_count
  );

  modport slave (
    input  char, key, rd_en,
    output ascii, empty, full, overflow, caps_lock, fill_count
  );
endinterface

// File: rtl/kbd_ascii_fifo.sv
// PS/2 Set-2 scan codes -> ASCII with Shift/Ctrl/Caps tracking, into a show-ahead FIFO.
// Char visible 3 edges after input sampled; no input backpressure, drops on full and sets sticky overflow.
module kbd_ascii_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic              clock,
  input logic              resetn,
  kbd_ascii_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic       key;
    logic [7:0] pre;
    logic [7:0] code;
  } scan_t;

  scan_t         in_q, prev_q;
  logic          shl_q, shl_d, shr_q, shr_d, ctrl_q, ctrl_d, caps_q, caps_d;
  logic          push_q, push_d;
  logic [7:0]    push_dat_q, push_dat_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic          lt_vld, dg_vld, ot_vld, xl_vld;
  logic [4:0]    lt_idx;
  logic [7:0]    dg_plain, dg_shift, ot_dat, xl_dat;
  logic          shift, new_code, pop, wr_en, full;

  // Translation table lookup on the code byte alone; modifiers applied afterwards.
  always_comb begin
    lt_vld = 1'b1;
    lt_idx = 5'd0;
    case (in_q.code)
      8'h1C: lt_idx = 5'd0;   8'h32: lt_idx = 5'd1;   8'h21: lt_idx = 5'd2;
      8'h23: lt_idx = 5'd3;   8'h24: lt_idx = 5'd4;   8'h2B: lt_idx = 5'd5;
      8'h34: lt_idx = 5'd6;   8'h33: lt_idx = 5'd7;   8'h43: lt_idx = 5'd8;
      8'h3B: lt_idx = 5'd9;   8'h42: lt_idx = 5'd10;  8'h4B: lt_idx = 5'd11;
      8'h3A: lt_idx = 5'd12;  8'h31: lt_idx = 5'd13;  8'h44: lt_idx = 5'd14;
      8'h4D: lt_idx = 5'd15;  8'h15: lt_idx = 5'd16;  8'h2D: lt_idx = 5'd17;
      8'h1B: lt_idx = 5'd18;  8'h2C: lt_idx = 5'd19;  8'h3C: lt_idx = 5'd20;
      8'h2A: lt_idx = 5'd21;  8'h1D: lt_idx = 5'd22;  8'h22: lt_idx = 5'd23;
      8'h35: lt_idx = 5'd24;  8'h1A: lt_idx = 5'd25;
      default: lt_vld = 1'b0;
    endcase

    dg_vld   = 1'b1;
    dg_plain = 8'h00;
    dg_shift = 8'h00;
    case (in_q.code)
      8'h45: begin dg_plain = 8'h30; dg_shift = 8'h29; end
      8'h16: begin dg_plain = 8'h31; dg_shift = 8'h21; end
      8'h1E: begin dg_plain = 8'h32; dg_shift = 8'h40; end
      8'h26: begin dg_plain = 8'h33; dg_shift = 8'h23; end
      8'h25: begin dg_plain = 8'h34; dg_shift = 8'h24; end
      8'h2E: begin dg_plain = 8'h35; dg_shift = 8'h25; end
      8'h36: begin dg_plain = 8'h36; dg_shift = 8'h5E; end
      8'h3D: begin dg_plain = 8'h37; dg_shift = 8'h26; end
      8'h3E: begin dg_plain = 8'h38; dg_shift = 8'h2A; end
      8'h46: begin dg_plain = 8'h39; dg_shift = 8'h28; end
      default: dg_vld = 1'b0;
    endcase

    ot_vld = 1'b1;
    ot_dat = 8'h00;
    case (in_q.code)
      8'h29: ot_dat = 8'h20;
      8'h5A: ot_dat = 8'h0D;
      8'h66: ot_dat = 8'h08;
      8'h76: ot_dat = 8'h1B;
      8'h0D: ot_dat = 8'h09;
      default: ot_vld = 1'b0;
    endcase
  end

  always_comb begin
    shift  = shl_q | shr_q;
    xl_vld = lt_vld | dg_vld | ot_vld;
    xl_dat = 8'h00;
    if (lt_vld) begin
      if (ctrl_q)              xl_dat = 8'h01 + {3'b000, lt_idx};
      else if (shift ^ caps_q) xl_dat = 8'h41 + {3'b000, lt_idx};
      else                     xl_dat = 8'h61 + {3'b000, lt_idx};
    end else if (dg_vld) begin
      xl_dat = shift ? dg_shift : dg_plain;
    end else if (ot_vld) begin
      xl_dat = ot_dat;
    end
  end

  // Only a change between consecutive receiver samples counts, so typematic repeats are ignored.
  always_comb begin
    new_code   = (in_q != prev_q);
    shl_d      = shl_q;
    shr_d      = shr_q;
    ctrl_d     = ctrl_q;
    caps_d     = caps_q;
    push_d     = 1'b0;
    push_dat_d = 8'h00;
    if (new_code) begin
      if (!in_q.key && in_q.pre == 8'h00 && in_q.code != 8'hE0 && in_q.code != 8'hF0) begin
        case (in_q.code)
          8'h12:   shl_d  = 1'b1;
          8'h59:   shr_d  = 1'b1;
          8'h14:   ctrl_d = 1'b1;
          8'h58:   caps_d = ~caps_q;
          default: begin
            push_d     = xl_vld;
            push_dat_d = xl_dat;
          end
        endcase
      end else if (in_q.key && in_q.pre == 8'hF0) begin
        case (in_q.code)
          8'h12:   shl_d  = 1'b0;
          8'h59:   shr_d  = 1'b0;
          8'h14:   ctrl_d = 1'b0;
          default: ;
        endcase
      end else if (in_q.key && in_q.pre == 8'hE0 && in_q.code == 8'h14) begin
        ctrl_d = 1'b1;
      end
    end
  end

  // A pop frees the slot the push needs, so a full FIFO still accepts on a read cycle.
  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    pop      = bus.rd_en && (cnt_q != '0);
    wr_en    = push_q && (!full || pop);
    ovf_d    = ovf_q | (push_q && full && !pop);
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_q       <= '0;
      prev_q     <= '0;
      shl_q      <= 1'b0;
      shr_q      <= 1'b0;
      ctrl_q     <= 1'b0;
      caps_q     <= 1'b0;
      push_q     <= 1'b0;
      push_dat_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      in_q       <= scan_t'({bus.key, bus.char});
      prev_q     <= in_q;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      ctrl_q     <= ctrl_d;
      caps_q     <= caps_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_q;
  end

  assign bus.ascii      = (cnt_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.empty      = (cnt_q == '0);
  assign bus.full       = full;
  assign bus.overflow   = ovf_q;
  assign bus.caps_lock  = caps_q;
  assign bus.fill_count = cnt_q;
endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed scan-code sequences against a queue-based keyboard/FIFO model checked every cycle,
// plus literal spot checks at the key points of each scenario.
module tb_kbd_ascii_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  kbd_ascii_fifo_if #(.DEPTH(DEPTH), .CW(CW)) bus_if ();
  kbd_ascii_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (.clock(clock), .resetn(resetn), .bus(bus_if));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] DIGITS [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string      SYMS         = ")!@#$%^&*(";

  logic [7:0]  mq[$];
  int          due_q[$];
  logic [7:0]  dch_q[$];
  logic [16:0] m_last = '0;
  bit          m_shl = 0, m_shr = 0, m_ctrl = 0, m_caps = 0, m_caps_vis = 0, m_ovf = 0;
  int          cyc = 0;

  function automatic logic [8:0] m_xlat(input logic [7:0] code);
    bit sh;
    sh = m_shl | m_shr;
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == code) begin
        if (m_ctrl)      return {1'b1, 8'(i + 1)};
        if (sh ^ m_caps) return {1'b1, 8'(8'h41 + i)};
        return {1'b1, 8'(8'h61 + i)};
      end
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == code) return {1'b1, sh ? SYMS[i] : 8'(8'h30 + i)};
    case (code)
      8'h29:   return {1'b1, 8'h20};
      8'h5A:   return {1'b1, 8'h0D};
      8'h66:   return {1'b1, 8'h08};
      8'h76:   return {1'b1, 8'h1B};
      8'h0D:   return {1'b1, 8'h09};
      default: return 9'h000;
    endcase
  endfunction

  function automatic void m_classify(input logic [16:0] v);
    logic [7:0] pre, code;
    logic [8:0] t;
    pre  = v[15:8];
    code = v[7:0];
    if (!v[16] && pre == 8'h00 && code != 8'hE0 && code != 8'hF0) begin
      if      (code == 8'h12) m_shl  = 1;
      else if (code == 8'h59) m_shr  = 1;
      else if (code == 8'h14) m_ctrl = 1;
      else if (code == 8'h58) m_caps = !m_caps;
      else begin
        t = m_xlat(code);
        if (t[8]) begin
          due_q.push_back(cyc + 2);
          dch_q.push_back(t[7:0]);
        end
      end
    end else if (v[16] && pre == 8'hF0) begin
      if      (code == 8'h12) m_shl  = 0;
      else if (code == 8'h59) m_shr  = 0;
      else if (code == 8'h14) m_ctrl = 0;
    end else if (v[16] && pre == 8'hE0 && code == 8'h14) begin
      m_ctrl = 1;
    end
  endfunction

  always @(posedge clock) begin
    logic [16:0] v;
    logic [7:0]  ch;
    if (!resetn) begin
      mq.delete(); due_q.delete(); dch_q.delete();
      m_last = '0; m_shl = 0; m_shr = 0; m_ctrl = 0; m_caps = 0; m_caps_vis = 0; m_ovf = 0;
      cyc = 0;
    end else begin
      cyc++;
      m_caps_vis = m_caps;
      if (bus_if.rd_en && mq.size() > 0) void'(mq.pop_front());
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        ch = dch_q.pop_front();
        if (mq.size() < DEPTH) mq.push_back(ch);
        else m_ovf = 1;
      end
      v = {bus_if.key, bus_if.char};
      if (v != m_last) m_classify(v);
      m_last = v;
    end
  end

  always @(negedge clock) begin
    int eh;
    eh = (mq.size() > 0) ? int'(mq[0]) : 0;
    chk("ascii",      int'(bus_if.ascii),      eh);
    chk("empty",      int'(bus_if.empty),      int'(mq.size() == 0));
    chk("full",       int'(bus_if.full),       int'(mq.size() == DEPTH));
    chk("overflow",   int'(bus_if.overflow),   int'(m_ovf));
    chk("caps_lock",  int'(bus_if.caps_lock),  int'(m_caps_vis));
    chk("fill_count", int'(bus_if.fill_count), mq.size());
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic k, input logic [15:0] c);
    @(negedge clock);
    bus_if.key  = k;
    bus_if.char = c;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pop_n(input int n);
    @(negedge clock);
    bus_if.rd_en = 1'b1;
    repeat (n) @(negedge clock);
    bus_if.rd_en = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] e);
    chk("lit_head", int'(bus_if.ascii), int'(e));
    bus_if.rd_en = 1'b1;
    @(negedge clock);
    bus_if.rd_en = 1'b0;
  endtask

  initial begin
    bus_if.key   = 1'b0;
    bus_if.char  = 16'h0000;
    bus_if.rd_en = 1'b0;
    idle(3);
    chk("lit_rst_empty", int'(bus_if.empty), 1);
    chk("lit_rst_ascii", int'(bus_if.ascii), 0);
    chk("lit_rst_count", int'(bus_if.fill_count), 0);
    resetn = 1'b1;

    // basic make, latency, break, typematic hold
    send(1'b0, 16'h001C);
    idle(2);
    chk("lit_lat_edge2_empty", int'(bus_if.empty), 1);
    idle(1);
    chk("lit_lat_edge3_empty", int'(bus_if.empty), 0);
    chk("lit_lat_edge3_ascii", int'(bus_if.ascii), 8'h61);
    send(1'b0, 16'h00F0);
    send(1'b1, 16'hF01C);
    idle(4);
    chk("lit_break_count", int'(bus_if.fill_count), 1);
    send(1'b0, 16'h001C);
    idle(100);
    chk("lit_hold_count", int'(bus_if.fill_count), 2);
    pop_n(2);
    chk("lit_drain_empty", int'(bus_if.empty), 1);

    // shift
    send(1'b0, 16'h0012); send(1'b0, 16'h001C); send(1'b0, 16'h0016);
    send(1'b0, 16'h00F0); send(1'b1, 16'hF012); send(1'b0, 16'h0016);
    send(1'b0, 16'h0029);
    idle(3);
    chk("lit_shift_count", int'(bus_if.fill_count), 4);
    pop_expect(8'h41); pop_expect(8'h21); pop_expect(8'h31); pop_expect(8'h20);

    // caps lock and ctrl
    send(1'b0, 16'h0058);
    idle(2);
    chk("lit_caps_on", int'(bus_if.caps_lock), 1);
    send(1'b0, 16'h001C); send(1'b0, 16'h0012); send(1'b0, 16'h001C);
    send(1'b0, 16'h00F0); send(1'b1, 16'hF012); send(1'b0, 16'h0016);
    send(1'b0, 16'h0014); send(1'b0, 16'h0021); send(1'b0, 16'h00F0);
    send(1'b1, 16'hF014); send(1'b1, 16'hE075);
    idle(3);
    chk("lit_caps_count", int'(bus_if.fill_count), 4);
    pop_expect(8'h41); pop_expect(8'h61); pop_expect(8'h31); pop_expect(8'h03);
    send(1'b0, 16'h0058); send(1'b0, 16'h00F0); send(1'b1, 16'hF058);
    idle(3);
    chk("lit_caps_off", int'(bus_if.caps_lock), 0);

    // fill to the brim, overflow, then push+pop while full
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'h001C);
      send(1'b0, 16'h0032);
    end
    idle(3);
    chk("lit_full", int'(bus_if.full), 1);
    chk("lit_full_count", int'(bus_if.fill_count), 16);
    send(1'b0, 16'h001C);
    idle(3);
    chk("lit_ovf", int'(bus_if.overflow), 1);
    chk("lit_ovf_count", int'(bus_if.fill_count), 16);
    chk("lit_ovf_head", int'(bus_if.ascii), 8'h61);
    send(1'b0, 16'h0032);
    idle(2);
    bus_if.rd_en = 1'b1;
    idle(1);
    bus_if.rd_en = 1'b0;
    chk("lit_pp_count", int'(bus_if.fill_count), 16);
    chk("lit_pp_ovf", int'(bus_if.overflow), 1);
    chk("lit_pp_head", int'(bus_if.ascii), 8'h62);
    pop_n(20);
    chk("lit_drain2_empty", int'(bus_if.empty), 1);

    // interleaved push/pop across pointer wrap
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus_if.key   = 1'b0;
      bus_if.char  = {8'h00, LETTERS[i % 26]};
      bus_if.rd_en = (i % 3 != 2);
    end
    @(negedge clock);
    bus_if.rd_en = 1'b0;
    idle(3);
    pop_n(20);
    chk("lit_wrap_empty", int'(bus_if.empty), 1);
    chk("lit_wrap_ascii", int'(bus_if.ascii), 0);

    // asynchronous reset mid-stream
    send(1'b0, 16'h0058);
    send(1'b0, 16'h001C); send(1'b0, 16'h0032); send(1'b0, 16'h0021);
    idle(3);
    chk("lit_pre_rst_count", int'(bus_if.fill_count), 3);
    chk("lit_pre_rst_caps", int'(bus_if.caps_lock), 1);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("lit_arst_empty", int'(bus_if.empty), 1);
    chk("lit_arst_ascii", int'(bus_if.ascii), 0);
    chk("lit_arst_count", int'(bus_if.fill_count), 0);
    chk("lit_arst_caps", int'(bus_if.caps_lock), 0);
    chk("lit_arst_ovf", int'(bus_if.overflow), 0);
    bus_if.key  = 1'b0;
    bus_if.char = 16'h0000;
    idle(2);
    resetn = 1'b1;
    send(1'b0, 16'h001C);
    idle(3);
    chk("lit_post_rst_ascii", int'(bus_if.ascii), 8'h61);
    chk("lit_post_rst_count", int'(bus_if.fill_count), 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
